// File: rtl/synapse_integrator_pkg.sv
// Shared SNN definitions: default sizes, integrator FSM encoding and the
// saturating adder used by both the synapse integrator and the neuron datapath.
package synapse_integrator_pkg;

  localparam int N_PRE_DEFAULT = 8;
  localparam int W_DEFAULT     = 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SCAN    = 2'd1;
  localparam logic [1:0] ST_PUBLISH = 2'd2;

  // Unsigned add clamped to 2^width-1; operands must already fit in width bits.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] width);
    logic [32:0] sum;
    logic [32:0] max_val;
    sum     = {1'b0, a} + {1'b0, b};
    max_val = (33'd1 << width) - 33'd1;
    return (sum > max_val) ? max_val[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/synapse_integrator_if.sv
// Tick/spike/weight-write inputs and published current outputs of the
// synapse integrator, bundled for the driver (master) and the block (slave).
interface synapse_integrator_if #(
  parameter int N_PRE = synapse_integrator_pkg::N_PRE_DEFAULT,
  parameter int W     = synapse_integrator_pkg::W_DEFAULT
) ();
  localparam int AW = $clog2(N_PRE);

  logic             tick;
  logic [N_PRE-1:0] spike_in;
  logic             w_we;
  logic [AW-1:0]    w_addr;
  logic [W-1:0]     w_data;
  logic [W-1:0]     post_synaptic;
  logic             post_valid;
  logic             busy;
  logic             overrun;

  modport master (
    output tick, spike_in, w_we, w_addr, w_data,
    input  post_synaptic, post_valid, busy, overrun
  );

  modport slave (
    input  tick, spike_in, w_we, w_addr, w_data,
    output post_synaptic, post_valid, busy, overrun
  );
endinterface

// File: rtl/synapse_integrator_weight_regfile.sv
// Synaptic weight store: one write port, one combinational read port.
// Writes to addresses outside 0..N_PRE-1 match no register and are dropped.
module weight_regfile #(
  parameter int N_PRE = 8,
  parameter int W     = 8,
  parameter int AW    = $clog2(N_PRE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [N_PRE-1:0][W-1:0] weight_vec;

  generate
    for (genvar gi = 0; gi < N_PRE; gi++) begin : g_weight
      logic [W-1:0] weight_q;
      logic [W-1:0] weight_d;

      always_comb begin
        weight_d = weight_q;
        if (we && (wr_addr == AW'(gi))) begin
          weight_d = wr_data;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          weight_q <= '0;
        end else begin
          weight_q <= weight_d;
        end
      end

      assign weight_vec[gi] = weight_q;
    end
  endgenerate

  // Read sees the pre-edge value, so a same-cycle write never affects it.
  assign rd_data = weight_vec[rd_addr];

endmodule

// File: rtl/synapse_integrator.sv
// Per-timestep synaptic current integrator: on each accepted tick it scans the
// latched spike vector one input per cycle and publishes the saturated sum.
module synapse_integrator
  import synapse_integrator_pkg::*;
#(
  parameter int N_PRE = N_PRE_DEFAULT,
  parameter int W     = W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  synapse_integrator_if.slave  bus
);

  localparam int AW = $clog2(N_PRE);
  localparam logic [AW-1:0] LAST_IDX = AW'(N_PRE - 1);

  logic [1:0]       state_q,   state_d;
  logic [AW-1:0]    index_q,   index_d;
  logic [W-1:0]     acc_q,     acc_d;
  logic [N_PRE-1:0] spikes_q,  spikes_d;
  logic [W-1:0]     post_q,    post_d;
  logic             valid_q,   valid_d;
  logic             overrun_q, overrun_d;

  logic [W-1:0] rd_weight;
  logic [W-1:0] addend;
  logic [W-1:0] acc_sum;

  weight_regfile #(
    .N_PRE (N_PRE),
    .W     (W),
    .AW    (AW)
  ) u_weight_regfile (
    .clk     (clk),
    .reset   (reset),
    .we      (bus.w_we),
    .wr_addr (bus.w_addr),
    .wr_data (bus.w_data),
    .rd_addr (index_q),
    .rd_data (rd_weight)
  );

  assign addend  = spikes_q[index_q] ? rd_weight : '0;
  assign acc_sum = W'(sat_add(32'(acc_q), 32'(addend), 32'(W)));

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    acc_d     = acc_q;
    spikes_d  = spikes_q;
    post_d    = post_q;
    valid_d   = 1'b0;
    // Any tick outside IDLE, including the PUBLISH cycle, is an overrun.
    overrun_d = overrun_q | (bus.tick && (state_q != ST_IDLE));

    case (state_q)
      ST_IDLE: begin
        if (bus.tick) begin
          spikes_d = bus.spike_in;
          acc_d    = '0;
          index_d  = '0;
          state_d  = ST_SCAN;
        end
      end
      ST_SCAN: begin
        acc_d = acc_sum;
        if (index_q == LAST_IDX) begin
          // Output registers load here so they are visible during PUBLISH.
          post_d  = acc_sum;
          valid_d = 1'b1;
          index_d = '0;
          state_d = ST_PUBLISH;
        end else begin
          index_d = index_q + AW'(1);
        end
      end
      ST_PUBLISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      index_q   <= '0;
      acc_q     <= '0;
      spikes_q  <= '0;
      post_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      acc_q     <= acc_d;
      spikes_q  <= spikes_d;
      post_q    <= post_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.post_synaptic = post_q;
  assign bus.post_valid    = valid_q;
  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.overrun       = overrun_q;

endmodule
